instr_selftest_seq: RTL and testbench



---
 rtl/mips_test_pkg.sv | 10 +
 rtl/instr_selftest_seq.sv | 168 ++++++++++++++++
 tb/tb_instr_selftest_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_test_pkg.sv
// mips_test_pkg: FSM states, probe kinds and code-segment PC shared by the MIPS self-test logic
package mips_test_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_HOLD, S_PRE_A, S_PRE_B, S_RUN, S_PROBE, S_CHECK, S_NEXT, S_DONE
   } st_e;
   localparam logic [1:0] KIND_GPR = 2'd0;
   localparam logic [1:0] KIND_DM = 2'd1;
   localparam logic [1:0] KIND_PC = 2'd2;
   localparam logic [31:0] CODE_SEG_PC = 32'h0000_3000;
endpackage

// File: rtl/instr_selftest_seq.sv
// instr_selftest_seq: loads, runs and checks one MIPS instruction per vector, counting passes and fails
module instr_selftest_seq
   import mips_test_pkg::*;
#(
   parameter int NUM_TESTS = 16,
   parameter int TIMEOUT = 64,
   parameter int RST_CYCLES = 2,
   parameter int MIN_RUN = 2,
   parameter int IW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
   parameter int CW = $clog2(NUM_TESTS + 1)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [IW-1:0] vec_idx,
   input  logic [31:0]   vec_instr,
   input  logic [1:0]    vec_kind,
   input  logic [31:0]   vec_addr,
   input  logic [31:0]   vec_pre_a,
   input  logic [31:0]   vec_pre_b,
   input  logic [1:0]    vec_pre_en,
   input  logic [31:0]   vec_expect,
   output logic          im_we,
   output logic [31:0]   im_wdata,
   output logic          gpr_we,
   output logic [4:0]    gpr_waddr,
   output logic [31:0]   gpr_wdata,
   output logic          cpu_rst,
   input  logic          cpu_s1,
   output logic [1:0]    probe_kind,
   output logic [31:0]   probe_addr,
   input  logic [31:0]   probe_data,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic [IW-1:0] first_fail,
   output logic          first_fail_vld,
   output logic          timeout_seen
);
   localparam int RW = $clog2(TIMEOUT + RST_CYCLES + 1);
   st_e state_q, state_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] vec_idx_q, vec_idx_d, first_fail_q, first_fail_d;
   logic [CW-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
   logic first_fail_vld_q, first_fail_vld_d, timeout_seen_q, timeout_seen_d;
   logic im_we_q, im_we_d, gpr_we_q, gpr_we_d, cpu_rst_q, cpu_rst_d, fail_rec;
   logic [31:0] im_wdata_q, im_wdata_d, gpr_wdata_q, gpr_wdata_d, probe_addr_q, probe_addr_d;
   logic [4:0] gpr_waddr_q, gpr_waddr_d;
   logic [1:0] probe_kind_q, probe_kind_d;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      vec_idx_d = vec_idx_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      first_fail_d = first_fail_q;
      first_fail_vld_d = first_fail_vld_q;
      timeout_seen_d = timeout_seen_q;
      fail_rec = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: if (start) begin
            state_d = S_LOAD;
            vec_idx_d = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            first_fail_d = '0;
            first_fail_vld_d = 1'b0;
            timeout_seen_d = 1'b0;
         end
         S_LOAD: begin
            state_d = S_HOLD;
            cnt_d = '0;
         end
         S_HOLD: if (cnt_q == RW'(RST_CYCLES - 1)) state_d = S_PRE_A;
            else cnt_d = cnt_q + 1'b1;
         S_PRE_A: state_d = S_PRE_B;
         S_PRE_B: begin
            state_d = S_RUN;
            cnt_d = '0;
         end
         S_RUN: if (cnt_q >= RW'(MIN_RUN) && cpu_s1) state_d = S_PROBE;
            else if (cnt_q == RW'(TIMEOUT - 1)) begin
               state_d = S_NEXT;
               timeout_seen_d = 1'b1;
               fail_rec = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         S_PROBE: state_d = S_CHECK;
         S_CHECK: begin
            state_d = S_NEXT;
            if (vec_kind <= KIND_PC && probe_data == vec_expect) pass_cnt_d = pass_cnt_q + 1'b1;
            else fail_rec = 1'b1;
         end
         S_NEXT: if (vec_idx_q == IW'(NUM_TESTS - 1)) state_d = S_DONE;
            else begin
               vec_idx_d = vec_idx_q + 1'b1;
               state_d = S_LOAD;
            end
         default: state_d = S_IDLE;
      endcase
      if (fail_rec) begin
         fail_cnt_d = fail_cnt_q + 1'b1;
         first_fail_d = first_fail_vld_q ? first_fail_q : vec_idx_q;
         first_fail_vld_d = 1'b1;
      end
      // the vector ROM only presents the new word once LOAD is entered, so the IM write trails by one cycle
      im_we_d = state_q == S_LOAD;
      im_wdata_d = (state_q == S_LOAD) ? vec_instr : im_wdata_q;
      gpr_we_d = (state_d == S_PRE_A && vec_pre_en[0]) || (state_d == S_PRE_B && vec_pre_en[1]);
      gpr_waddr_d = !gpr_we_d ? gpr_waddr_q : (state_d == S_PRE_B) ? vec_instr[20:16] : vec_instr[25:21];
      gpr_wdata_d = !gpr_we_d ? gpr_wdata_q : (state_d == S_PRE_B) ? vec_pre_b : vec_pre_a;
      cpu_rst_d = state_d inside {S_IDLE, S_LOAD, S_HOLD, S_NEXT, S_DONE};
      probe_kind_d = (state_d == S_PROBE) ? vec_kind : probe_kind_q;
      probe_addr_d = (state_d == S_PROBE) ? vec_addr : probe_addr_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         vec_idx_q <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         first_fail_q <= '0;
         first_fail_vld_q <= 1'b0;
         timeout_seen_q <= 1'b0;
         im_we_q <= 1'b0;
         im_wdata_q <= '0;
         gpr_we_q <= 1'b0;
         gpr_waddr_q <= '0;
         gpr_wdata_q <= '0;
         cpu_rst_q <= 1'b1;
         probe_kind_q <= '0;
         probe_addr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         vec_idx_q <= vec_idx_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         first_fail_q <= first_fail_d;
         first_fail_vld_q <= first_fail_vld_d;
         timeout_seen_q <= timeout_seen_d;
         im_we_q <= im_we_d;
         im_wdata_q <= im_wdata_d;
         gpr_we_q <= gpr_we_d;
         gpr_waddr_q <= gpr_waddr_d;
         gpr_wdata_q <= gpr_wdata_d;
         cpu_rst_q <= cpu_rst_d;
         probe_kind_q <= probe_kind_d;
         probe_addr_q <= probe_addr_d;
      end
   assign vec_idx = vec_idx_q;
   assign im_we = im_we_q;
   assign im_wdata = im_wdata_q;
   assign gpr_we = gpr_we_q;
   assign gpr_waddr = gpr_waddr_q;
   assign gpr_wdata = gpr_wdata_q;
   assign cpu_rst = cpu_rst_q;
   assign probe_kind = probe_kind_q;
   assign probe_addr = probe_addr_q;
   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
   assign first_fail = first_fail_q;
   assign first_fail_vld = first_fail_vld_q;
   assign timeout_seen = timeout_seen_q;
   assign busy = !(state_q inside {S_IDLE, S_DONE});
   assign done = state_q == S_DONE;
endmodule

// File: tb/tb_instr_selftest_seq.sv
// tb_instr_selftest_seq: scoreboard bench driving the sequencer against a tiny behavioural MIPS core
module tb_instr_selftest_seq;
   logic clk = 0, rst = 1, start = 0, s1_en = 1;
   logic [1:0] vec_idx, vec_kind, vec_pre_en, probe_kind, pass_cnt, fail_cnt, first_fail;
   logic [31:0] vec_instr, vec_addr, vec_pre_a, vec_pre_b, vec_expect, im_wdata, gpr_wdata, probe_addr, probe_data;
   logic im_we, gpr_we, cpu_rst, cpu_s1, busy, done, first_fail_vld, timeout_seen;
   logic [4:0] gpr_waddr;
   always #5 clk = ~clk;
   instr_selftest_seq #(.NUM_TESTS(3), .TIMEOUT(8), .RST_CYCLES(2), .MIN_RUN(2)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_idx(vec_idx), .vec_instr(vec_instr), .vec_kind(vec_kind),
      .vec_addr(vec_addr), .vec_pre_a(vec_pre_a), .vec_pre_b(vec_pre_b), .vec_pre_en(vec_pre_en),
      .vec_expect(vec_expect), .im_we(im_we), .im_wdata(im_wdata), .gpr_we(gpr_we), .gpr_waddr(gpr_waddr),
      .gpr_wdata(gpr_wdata), .cpu_rst(cpu_rst), .cpu_s1(cpu_s1), .probe_kind(probe_kind), .probe_addr(probe_addr),
      .probe_data(probe_data), .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail(first_fail), .first_fail_vld(first_fail_vld), .timeout_seen(timeout_seen));
   // vector ROM
   logic [31:0] r_instr[4], r_addr[4], r_pa[4], r_pb[4], r_exp[4];
   logic [1:0] r_kind[4], r_en[4];
   assign vec_instr = r_instr[vec_idx];
   assign vec_kind = r_kind[vec_idx];
   assign vec_addr = r_addr[vec_idx];
   assign vec_pre_a = r_pa[vec_idx];
   assign vec_pre_b = r_pb[vec_idx];
   assign vec_pre_en = r_en[vec_idx];
   assign vec_expect = r_exp[vec_idx];
   // behavioural core: executes the loaded word once, then sits in S1
   logic [31:0] gpr[32], dm[64], im_word, pc, m_rs, m_rt, m_simm, m_ea;
   int ccnt;
   assign m_rs = gpr[im_word[25:21]];
   assign m_rt = gpr[im_word[20:16]];
   assign m_simm = {{16{im_word[15]}}, im_word[15:0]};
   assign m_ea = m_rs + m_simm;
   assign cpu_s1 = s1_en && (ccnt <= 2 || ccnt >= 5);
   assign probe_data = probe_kind == 2'd0 ? gpr[probe_addr[4:0]] : probe_kind == 2'd1 ? dm[probe_addr[7:2]] :
                       probe_kind == 2'd2 ? pc : 32'hdead_beef;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) gpr[i] <= '0;
         for (int i = 0; i < 64; i++) dm[i] <= (i == 8) ? 32'h1234_5678 : 32'h0;
         im_word <= '0;
         pc <= 32'h3000;
         ccnt <= 0;
      end else begin
         if (im_we) im_word <= im_wdata;
         if (gpr_we && gpr_waddr != 0) gpr[gpr_waddr] <= gpr_wdata;
         if (cpu_rst) begin
            ccnt <= 0;
            pc <= 32'h3000;
         end else begin
            ccnt <= ccnt + 1;
            if (ccnt == 4) begin
               pc <= pc + 4;
               case (im_word[31:26])
                  6'h00: if (im_word[5:0] == 6'h21 && im_word[15:11] != 0) gpr[im_word[15:11]] <= m_rs + m_rt;
                  6'h04: if (m_rs == m_rt) pc <= pc + 4 + (m_simm << 2);
                  6'h23: if (im_word[20:16] != 0) gpr[im_word[20:16]] <= dm[m_ea[7:2]];
                  6'h2b: dm[m_ea[7:2]] <= m_rt;
                  default: ;
               endcase
            end
         end
      end
   end
   // scoreboard
   typedef struct packed {logic [4:0] a; logic [31:0] d;} gw_t;
   typedef struct packed {logic [1:0] p, f; logic ffv; logic [1:0] ff; logic to; logic [1:0] idx;} res_t;
   gw_t q_gpr[$];
   logic [31:0] q_im[$];
   int q_len[$];
   res_t q_res[$];
   int checks = 0, errors = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
      end
   endtask
   task automatic unexp(input string nm);
      checks++;
      errors++;
      $display("FAIL %s unexpected event @%0t", nm, $time);
   endtask
   logic done_prev = 0;
   int low_len = 0;
   res_t r;
   always @(negedge clk) begin
      if (im_we) begin
         if (q_im.size() > 0) chk("im_wdata", im_wdata, q_im.pop_front());
         else unexp("im_we");
      end
      if (gpr_we) begin
         if (q_gpr.size() > 0) chk("gpr_write", {gpr_waddr, gpr_wdata}, q_gpr.pop_front());
         else unexp("gpr_we");
      end
      if (!cpu_rst) low_len++;
      else begin
         if (low_len > 0 && q_len.size() > 0) chk("run_window", low_len, q_len.pop_front());
         low_len = 0;
      end
      if (done && !done_prev) begin
         if (q_res.size() > 0) begin
            r = q_res.pop_front();
            chk("pass_cnt", pass_cnt, r.p);
            chk("fail_cnt", fail_cnt, r.f);
            chk("first_fail_vld", first_fail_vld, r.ffv);
            chk("first_fail", first_fail, r.ff);
            chk("timeout_seen", timeout_seen, r.to);
            chk("vec_idx_end", vec_idx, r.idx);
         end else unexp("done");
      end
      done_prev = done;
   end
   task automatic setv(input int i, input logic [31:0] ins, input logic [1:0] k, input logic [31:0] a, pa, pb,
                       input logic [1:0] en, input logic [31:0] e);
      r_instr[i] = ins; r_kind[i] = k; r_addr[i] = a; r_pa[i] = pa; r_pb[i] = pb; r_en[i] = en; r_exp[i] = e;
   endtask
   task automatic expect_vec(input int i, input int len);
      q_im.push_back(r_instr[i]);
      if (r_en[i][0]) q_gpr.push_back({r_instr[i][25:21], r_pa[i]});
      if (r_en[i][1]) q_gpr.push_back({r_instr[i][20:16], r_pb[i]});
      if (len > 0) q_len.push_back(len);
   endtask
   task automatic expect_run(input int len, input res_t res);
      for (int i = 0; i < 3; i++) expect_vec(i, len);
      q_res.push_back(res);
   endtask
   task automatic pulse_start();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask
   task automatic wait_done(input string nm);
      int n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done) unexp({nm, "_done_timeout"});
      repeat (2) @(negedge clk);
   endtask
   task automatic wait_idx1_running();
      int n = 0;
      while (!(vec_idx == 2'd1 && !cpu_rst) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) unexp("vec1_wait_timeout");
   endtask
   task automatic load_mem_vecs();
      setv(0, 32'h1022_0002, 2'd2, 32'd0, 32'd5, 32'd5, 2'b11, 32'h0000_300c);
      setv(1, 32'h8d09_0000, 2'd0, 32'd9, 32'd32, 32'd0, 2'b01, 32'h1234_5678);
      setv(2, 32'had09_0010, 2'd1, 32'd16, 32'd0, 32'h3456_7890, 2'b11, 32'h3456_7890);
   endtask
   initial begin
      setv(3, 32'h0, 2'd0, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0);
      repeat (2) @(negedge clk);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_busy_done", {busy, done, im_we, gpr_we}, 0);
      chk("rst_counts", {pass_cnt, fail_cnt, vec_idx, first_fail, first_fail_vld, timeout_seen}, 0);
      chk("rst_probe", {probe_kind, probe_addr, gpr_waddr, gpr_wdata, im_wdata}, 0);
      rst = 0;
      @(negedge clk);
      // run 1: ADDU pass, ADDU wrong expect, reserved kind
      setv(0, 32'h0109_5021, 2'd0, 32'd10, 32'h1234_5678, 32'h7654_3210, 2'b11, 32'h8888_8888);
      setv(1, 32'h0109_5021, 2'd0, 32'd10, 32'h1234_5678, 32'h7654_3210, 2'b11, 32'h8888_8889);
      setv(2, 32'h0000_0000, 2'd3, 32'd0, 32'h0, 32'h0, 2'b00, 32'hdead_beef);
      expect_run(8, '{p: 2'd1, f: 2'd2, ffv: 1'b1, ff: 2'd1, to: 1'b0, idx: 2'd2});
      start = 1;
      @(posedge clk) #1 chk("start_busy", {busy, im_we}, 2'b10);
      start = 0;
      @(posedge clk) #1 chk("start_to_im_we", im_we, 1);
      wait_done("run1");
      chk("run1_probe", {probe_kind, probe_addr}, {2'd3, 32'd0});
      // run 2: BEQ taken, LW, SW
      load_mem_vecs();
      expect_run(8, '{p: 2'd3, f: 2'd0, ffv: 1'b0, ff: 2'd0, to: 1'b0, idx: 2'd2});
      pulse_start();
      wait_done("run2");
      chk("run2_probe", {probe_kind, probe_addr}, {2'd1, 32'd16});
      // run 3: core never reaches S1
      s1_en = 0;
      for (int i = 0; i < 3; i++)
         setv(i, 32'h0109_5021, 2'd0, 32'd7, 32'h1, 32'h2, 2'b11, 32'h3);
      expect_run(10, '{p: 2'd0, f: 2'd3, ffv: 1'b1, ff: 2'd0, to: 1'b1, idx: 2'd2});
      pulse_start();
      wait_done("run3");
      chk("timeout_no_probe", {probe_kind, probe_addr}, {2'd1, 32'd16});
      s1_en = 1;
      // run 4: reset during RUN of vector 1, then a clean rerun
      load_mem_vecs();
      expect_vec(0, 8);
      expect_vec(1, 0);
      pulse_start();
      wait_idx1_running();
      repeat (3) @(negedge clk);
      chk("pre_abort_pass", pass_cnt, 1);
      #2 rst = 1;
      #1 chk("abort_cpu_rst", cpu_rst, 1);
      chk("abort_state", {busy, done, pass_cnt, fail_cnt, vec_idx, probe_kind}, 0);
      @(negedge clk) rst = 0;
      @(negedge clk) chk("abort_idle", {busy, cpu_rst, vec_idx}, {1'b0, 1'b1, 2'd0});
      expect_run(8, '{p: 2'd3, f: 2'd0, ffv: 1'b0, ff: 2'd0, to: 1'b0, idx: 2'd2});
      pulse_start();
      wait_done("rerun");
      // run 5: start while busy must not restart
      expect_run(8, '{p: 2'd3, f: 2'd0, ffv: 1'b0, ff: 2'd0, to: 1'b0, idx: 2'd2});
      pulse_start();
      wait_idx1_running();
      pulse_start();
      wait_done("run5");
      chk("queues_drained", q_im.size() + q_gpr.size() + q_res.size() + q_len.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
